// File: rtl/ckpt_regfile.sv
// Multi-port integer register file with forwarding and CKPT_CNT full-state
// checkpoint slots for single-cycle rollback of speculative branch state.
module ckpt_regfile #(
  parameter int READ_PORTS  = 3,
  parameter int WRITE_PORTS = 2,
  parameter int XLEN        = 32,
  parameter int REG_CNT     = 32,
  parameter int CKPT_CNT    = 4,
  localparam int AW = $clog2(REG_CNT),
  localparam int CW = (CKPT_CNT > 1) ? $clog2(CKPT_CNT) : 1,
  localparam int FW = $clog2(CKPT_CNT + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [WRITE_PORTS-1:0]              wr_en,
  input  logic [WRITE_PORTS-1:0][AW-1:0]      wr_addr,
  input  logic [WRITE_PORTS-1:0][XLEN-1:0]    wr_data,
  input  logic [READ_PORTS-1:0]               rd_en,
  input  logic [READ_PORTS-1:0][AW-1:0]       rd_addr,
  output logic [READ_PORTS-1:0][XLEN-1:0]     rd_data,
  output logic [READ_PORTS-1:0]               rd_valid,
  input  logic                                ckpt_take,
  output logic                                ckpt_ack,
  output logic [CW-1:0]                       ckpt_id,
  input  logic                                ckpt_restore,
  input  logic [CW-1:0]                       restore_id,
  input  logic                                ckpt_release,
  input  logic [CW-1:0]                       release_id,
  output logic                                ckpt_full,
  output logic [FW-1:0]                       ckpt_free_cnt,
  output logic                                ckpt_err
);

  logic [XLEN-1:0] mem_q  [REG_CNT];
  logic [XLEN-1:0] mem_d  [REG_CNT];
  logic [XLEN-1:0] wr_img [REG_CNT];
  logic [XLEN-1:0] snap_q [CKPT_CNT][REG_CNT];
  logic [XLEN-1:0] snap_d [CKPT_CNT][REG_CNT];

  logic [CKPT_CNT-1:0] alloc_q, alloc_d;
  logic                ack_q, ack_d;
  logic [CW-1:0]       id_q, id_d;
  logic [FW-1:0]       free_cnt_q, free_cnt_d;
  logic                full_q, full_d;
  logic                err_q, err_d;

  logic          restore_ok, release_ok, take_ok, have_free;
  logic [CW-1:0] take_slot;

  // Read path: write ports forward into reads; higher port index overrides.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    rd_data = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      if (en && rd_en[i] && rd_addr[i] != '0) begin
        rd_data[i] = mem_q[rd_addr[i]];
        for (int j = 0; j < WRITE_PORTS; j++)
          if (wr_en[j] && wr_addr[j] == rd_addr[i]) rd_data[i] = wr_data[j];
      end
    end
  end

  assign rd_valid = {READ_PORTS{en}} & rd_en;

  // Lowest free slot, judged on the pre-edge allocation state.
  always_comb begin
    take_slot = '0;
    have_free = 1'b0;
    for (int s = CKPT_CNT - 1; s >= 0; s--) begin
      if (!alloc_q[s]) begin
        take_slot = CW'(s);
        have_free = 1'b1;
      end
    end
  end

  assign restore_ok = en && ckpt_restore && alloc_q[restore_id];
  assign release_ok = en && ckpt_release && alloc_q[release_id];
  assign take_ok    = en && ckpt_take && !ckpt_restore && have_free;

  always_comb begin
    wr_img = mem_q;
    for (int j = 0; j < WRITE_PORTS; j++)
      if (en && wr_en[j] && wr_addr[j] != '0) wr_img[wr_addr[j]] = wr_data[j];

    // A successful restore discards this cycle's writes entirely.
    mem_d  = restore_ok ? snap_q[restore_id] : wr_img;
    snap_d = snap_q;
    if (take_ok) snap_d[take_slot] = wr_img;

    alloc_d = alloc_q;
    if (take_ok)    alloc_d[take_slot]  = 1'b1;
    if (release_ok) alloc_d[release_id] = 1'b0;
    if (restore_ok) alloc_d[restore_id] = 1'b0;

    free_cnt_d = '0;
    for (int s = 0; s < CKPT_CNT; s++)
      if (!alloc_d[s]) free_cnt_d = free_cnt_d + FW'(1);
    full_d = (free_cnt_d == '0);

    ack_d = take_ok;
    id_d  = take_ok ? take_slot : id_q;
    err_d = err_q
          | (en && ckpt_restore && !alloc_q[restore_id])
          | (en && ckpt_release && !alloc_q[release_id]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register and snapshot arrays are reset because the branch
      // unit relies on a zeroed architectural image; this keeps them in flops
      // rather than RAM macros.
      mem_q      <= '{default: '0};
      snap_q     <= '{default: '0};
      alloc_q    <= '0;
      ack_q      <= 1'b0;
      id_q       <= '0;
      free_cnt_q <= FW'(CKPT_CNT);
      full_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q      <= mem_d;
      snap_q     <= snap_d;
      alloc_q    <= alloc_d;
      ack_q      <= ack_d;
      id_q       <= id_d;
      free_cnt_q <= free_cnt_d;
      full_q     <= full_d;
      err_q      <= err_d;
    end
  end

  assign ckpt_ack      = ack_q;
  assign ckpt_id       = id_q;
  assign ckpt_free_cnt = free_cnt_q;
  assign ckpt_full     = full_q;
  assign ckpt_err      = err_q;

endmodule

// File: tb/tb_ckpt_regfile.sv
// Directed bench for ckpt_regfile: a behavioural model checked every cycle,
// plus hand-computed literal expectations along the scenario.
module tb_ckpt_regfile;
  localparam int R = 3, W = 2, XLEN = 32, REG_CNT = 32, CK = 4;
  localparam int AW = $clog2(REG_CNT), CW = $clog2(CK), FW = $clog2(CK + 1);

  logic clk = 1'b0, rst, en;
  logic [W-1:0]           wr_en;
  logic [W-1:0][AW-1:0]   wr_addr;
  logic [W-1:0][XLEN-1:0] wr_data;
  logic [R-1:0]           rd_en;
  logic [R-1:0][AW-1:0]   rd_addr;
  logic [R-1:0][XLEN-1:0] rd_data;
  logic [R-1:0]           rd_valid;
  logic ckpt_take, ckpt_ack, ckpt_restore, ckpt_release, ckpt_full, ckpt_err;
  logic [CW-1:0] ckpt_id, restore_id, release_id;
  logic [FW-1:0] ckpt_free_cnt;

  int n_checks = 0, n_fail = 0;

  ckpt_regfile #(.READ_PORTS(R), .WRITE_PORTS(W), .XLEN(XLEN),
                 .REG_CNT(REG_CNT), .CKPT_CNT(CK)) dut (
    .clk(clk), .rst(rst), .en(en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .ckpt_take(ckpt_take), .ckpt_ack(ckpt_ack), .ckpt_id(ckpt_id),
    .ckpt_restore(ckpt_restore), .restore_id(restore_id),
    .ckpt_release(ckpt_release), .release_id(release_id),
    .ckpt_full(ckpt_full), .ckpt_free_cnt(ckpt_free_cnt), .ckpt_err(ckpt_err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural registers, snapshots and slot ownership.
  logic [XLEN-1:0] m_mem  [REG_CNT];
  logic [XLEN-1:0] m_snap [CK][REG_CNT];
  bit   m_alloc [CK];
  bit   m_ack, m_err;
  int   m_id;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_mem[a]) m_mem[a] = '0;
      foreach (m_snap[s, a]) m_snap[s][a] = '0;
      foreach (m_alloc[s]) m_alloc[s] = 0;
      m_ack = 0; m_err = 0; m_id = 0;
    end else if (!en) begin
      m_ack = 0;
    end else begin
      logic [XLEN-1:0] img [REG_CNT];
      int free_slot;
      bit rs_hit, rl_hit;
      img = m_mem;
      for (int j = 0; j < W; j++)
        if (wr_en[j] && wr_addr[j] != 0) img[wr_addr[j]] = wr_data[j];
      free_slot = -1;
      for (int s = CK - 1; s >= 0; s--) if (!m_alloc[s]) free_slot = s;
      rs_hit = ckpt_restore && m_alloc[restore_id];
      rl_hit = ckpt_release && m_alloc[release_id];
      if (ckpt_restore && !m_alloc[restore_id]) m_err = 1;
      if (ckpt_release && !m_alloc[release_id]) m_err = 1;
      m_ack = ckpt_take && !ckpt_restore && free_slot >= 0;
      if (rs_hit) m_mem = m_snap[restore_id];
      else        m_mem = img;
      if (m_ack) begin
        m_id = free_slot;
        m_snap[free_slot] = img;
        m_alloc[free_slot] = 1;
      end
      if (rl_hit) m_alloc[release_id] = 0;
      if (rs_hit) m_alloc[restore_id] = 0;
    end
  end

  function automatic logic [XLEN-1:0] m_read(int i);
    logic [XLEN-1:0] v;
    if (!(en && rd_en[i]) || rd_addr[i] == 0) return '0;
    v = m_mem[rd_addr[i]];
    for (int j = 0; j < W; j++) if (wr_en[j] && wr_addr[j] == rd_addr[i]) v = wr_data[j];
    return v;
  endfunction

  function automatic int m_free();
    int c = 0;
    foreach (m_alloc[s]) if (!m_alloc[s]) c++;
    return c;
  endfunction

  // Compare process: every cycle out of reset, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < R; i++) begin
        check($sformatf("cmp_rd_valid%0d", i), 64'(rd_valid[i]), 64'(en && rd_en[i]));
        check($sformatf("cmp_rd_data%0d", i), 64'(rd_data[i]), 64'(m_read(i)));
      end
      check("cmp_ack", 64'(ckpt_ack), 64'(m_ack));
      check("cmp_id", 64'(ckpt_id), 64'(m_id));
      check("cmp_free_cnt", 64'(ckpt_free_cnt), 64'(m_free()));
      check("cmp_full", 64'(ckpt_full), 64'(m_free() == 0));
      check("cmp_err", 64'(ckpt_err), 64'(m_err));
    end
  end

  task automatic clr();
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
    ckpt_take = 0; ckpt_restore = 0; ckpt_release = 0; restore_id = '0; release_id = '0;
  endtask

  task automatic nxt();
    @(posedge clk); #1; clr();
  endtask

  task automatic wr(input int p, input int a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1; wr_addr[p] = AW'(a); wr_data[p] = d;
  endtask

  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1; rd_addr[p] = AW'(a);
  endtask

  initial begin
    rst = 1; en = 0; clr();
    rd(0, 5);
    @(negedge clk);
    check("rst_free_cnt", 64'(ckpt_free_cnt), 64'd4);
    check("rst_ack", 64'(ckpt_ack), 64'd0);
    check("rst_id", 64'(ckpt_id), 64'd0);
    check("rst_full", 64'(ckpt_full), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0; en = 1; clr();

    // Forwarding, registered visibility, x0 hardwired.
    nxt(); wr(0, 5, 32'hDEADBEEF); rd(0, 5);
    @(negedge clk); check("fwd_x5", 64'(rd_data[0]), 64'hDEADBEEF);
    nxt(); rd(0, 5);
    @(negedge clk); check("mem_x5", 64'(rd_data[0]), 64'hDEADBEEF);
    nxt(); wr(0, 0, 32'h1); rd(1, 0);
    @(negedge clk); check("fwd_x0", 64'(rd_data[1]), 64'd0);
    nxt(); rd(1, 0);
    @(negedge clk); check("mem_x0", 64'(rd_data[1]), 64'd0);

    // Same-address write on two ports: port 1 wins.
    nxt(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(2, 7);
    @(negedge clk); check("fwd_x7_prio", 64'(rd_data[2]), 64'h22);
    nxt(); rd(2, 7);
    @(negedge clk); check("mem_x7_prio", 64'(rd_data[2]), 64'h22);

    // Take, modify, restore.
    nxt(); wr(0, 1, 32'hA); wr(1, 3, 32'h33);
    nxt(); ckpt_take = 1;
    nxt();
    @(negedge clk);
    check("take_ack", 64'(ckpt_ack), 64'd1);
    check("take_id", 64'(ckpt_id), 64'd0);
    check("take_free", 64'(ckpt_free_cnt), 64'd3);
    nxt(); wr(0, 1, 32'hB);
    nxt(); ckpt_restore = 1; restore_id = 0;
    nxt(); rd(0, 1);
    @(negedge clk);
    check("restore_x1", 64'(rd_data[0]), 64'hA);
    check("restore_free", 64'(ckpt_free_cnt), 64'd4);

    // Fill all slots, then overflow.
    for (int k = 0; k < 5; k++) begin
      nxt(); ckpt_take = 1;
      @(negedge clk);
      if (k > 0) begin
        check("fill_ack", 64'(ckpt_ack), 64'd1);
        check("fill_id", 64'(ckpt_id), 64'(k - 1));
      end
    end
    check("fill_full", 64'(ckpt_full), 64'd1);
    nxt();
    @(negedge clk);
    check("overflow_ack", 64'(ckpt_ack), 64'd0);
    check("overflow_id", 64'(ckpt_id), 64'd3);
    nxt(); ckpt_release = 1; release_id = 2; ckpt_take = 1;
    nxt();
    @(negedge clk);
    check("rel_take_ack", 64'(ckpt_ack), 64'd0);
    check("rel_take_free", 64'(ckpt_free_cnt), 64'd1);
    nxt(); ckpt_take = 1;
    nxt();
    @(negedge clk);
    check("retake_ack", 64'(ckpt_ack), 64'd1);
    check("retake_id", 64'(ckpt_id), 64'd2);
    check("retake_full", 64'(ckpt_full), 64'd1);

    // Restore drops same-cycle write and take.
    nxt(); ckpt_restore = 1; restore_id = 1; wr(0, 3, 32'h55); ckpt_take = 1;
    nxt(); rd(0, 3);
    @(negedge clk);
    check("rs_drop_x3", 64'(rd_data[0]), 64'h33);
    check("rs_drop_ack", 64'(ckpt_ack), 64'd0);
    check("rs_drop_free", 64'(ckpt_free_cnt), 64'd1);

    // Restore of an unallocated slot: ignored, sticky error.
    nxt(); ckpt_release = 1; release_id = 3;
    nxt(); ckpt_restore = 1; restore_id = 3;
    nxt();
    @(negedge clk);
    check("err_set", 64'(ckpt_err), 64'd1);
    check("err_free", 64'(ckpt_free_cnt), 64'd2);
    nxt();
    @(negedge clk); check("err_sticky", 64'(ckpt_err), 64'd1);

    // Global enable low: no reads valid, no state change.
    nxt(); en = 0; wr(0, 9, 32'h99); ckpt_take = 1; rd(0, 9);
    @(negedge clk);
    check("dis_valid", 64'(rd_valid[0]), 64'd0);
    check("dis_data", 64'(rd_data[0]), 64'd0);
    nxt(); en = 1; rd(0, 9);
    @(negedge clk);
    check("dis_x9", 64'(rd_data[0]), 64'd0);
    check("dis_ack", 64'(ckpt_ack), 64'd0);
    check("dis_free", 64'(ckpt_free_cnt), 64'd2);

    // Asynchronous reset mid-operation.
    nxt(); rst = 1;
    @(negedge clk);
    check("rst2_err", 64'(ckpt_err), 64'd0);
    check("rst2_free", 64'(ckpt_free_cnt), 64'd4);
    check("rst2_id", 64'(ckpt_id), 64'd0);
    nxt(); rst = 0; rd(0, 1);
    @(negedge clk); check("rst2_x1", 64'(rd_data[0]), 64'd0);
    nxt();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
